// File: rtl/vx_mem_responder.sv
// Memory-side responder: byte-enabled RAM model with fixed-latency,
// in-order, tagged read responses and credit-based request flow control.
// Ports:
//   clk, reset_n          clock / async active-low reset
//   req_valid/req_ready   request handshake (rw, byteen, addr, data, tag)
//   rsp_valid/rsp_ready   read response handshake (rsp_data, rsp_tag)
module vx_mem_responder #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 8,
  parameter int TAG_WIDTH  = 8,
  parameter int DATA_SIZE  = DATA_WIDTH / 8,
  parameter int LATENCY    = 2,
  parameter int RSP_QUEUE  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  input  logic                  req_rw,
  input  logic [DATA_SIZE-1:0]  req_byteen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic                  rsp_ready
);

  localparam int CW    = $clog2(RSP_QUEUE + 1);
  localparam int PW    = (RSP_QUEUE > 1) ? $clog2(RSP_QUEUE) : 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [CW-1:0] outstanding;
  logic          rd_fire;
  logic          wr_fire;
  logic          rsp_fire;

  assign req_ready = (outstanding < CW'(RSP_QUEUE));
  assign rd_fire   = req_valid && req_ready && !req_rw;
  assign wr_fire   = req_valid && req_ready && req_rw;
  assign rsp_fire  = rsp_valid && rsp_ready;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;

  // RAM is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < DATA_SIZE; i++) begin
        if (req_byteen[i]) begin
          mem[req_addr][8*i +: 8] <= req_data[8*i +: 8];
        end
      end
    end
  end

  assign rd_data = mem[req_addr];

  // The FIFO register supplies one cycle of latency, so the
  // delay line holds LATENCY-1 stages.
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic [TAG_WIDTH-1:0]  push_tag;

  if (LATENCY == 1) begin : g_nodly
    assign push_valid = rd_fire;
    assign push_data  = rd_data;
    assign push_tag   = req_tag;
  end else begin : g_dly
    localparam int S = LATENCY - 1;
    logic [S-1:0]          pv;
    logic [DATA_WIDTH-1:0] pd [S];
    logic [TAG_WIDTH-1:0]  pt [S];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pv <= '0;
      end else begin
        pv[0] <= rd_fire;
        for (int i = 1; i < S; i++) begin
          pv[i] <= pv[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      pd[0] <= rd_data;
      pt[0] <= req_tag;
      for (int i = 1; i < S; i++) begin
        pd[i] <= pd[i-1];
        pt[i] <= pt[i-1];
      end
    end

    assign push_valid = pv[S-1];
    assign push_data  = pd[S-1];
    assign push_tag   = pt[S-1];
  end

  // Credits bound the FIFO occupancy, so push never sees it full.
  logic [DATA_WIDTH-1:0] fd [RSP_QUEUE];
  logic [TAG_WIDTH-1:0]  ft [RSP_QUEUE];
  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic [CW-1:0]         cnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RSP_QUEUE - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < RSP_QUEUE; i++) begin
        fd[i] <= '0;
        ft[i] <= '0;
      end
    end else begin
      if (push_valid) begin
        fd[wp] <= push_data;
        ft[wp] <= push_tag;
        wp     <= nxt(wp);
      end
      if (rsp_fire) begin
        rp <= nxt(rp);
      end
      unique case ({push_valid, rsp_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rsp_valid = (cnt != '0);
  assign rsp_data  = fd[rp];
  assign rsp_tag   = ft[rp];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else begin
      unique case ({rd_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
